// File: rtl/scan_row_bound_ctrl_pkg.sv
// Shared types and constants for the row bound scanner.
package scan_row_bound_ctrl_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int COL_W  = 10;
   localparam int OFF_W  = 5;
   localparam int IDX_W  = 5;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WAIT_RD  = 3'd2,
      DET      = 3'd3,
      WAIT_DET = 3'd4,
      FINISH   = 3'd5
   } state_t;

   // A word is 32 pixels wide, so column = offset*32 + bit is a plain concatenation.
   function automatic logic [COL_W-1:0] word_bit_to_col(input logic [OFF_W-1:0] off,
                                                         input logic [IDX_W-1:0] idx);
      return {off, idx};
   endfunction

endpackage

// File: rtl/scan_row_bound_ctrl_det_timeout_cnt.sv
// Detector watchdog: cleared on trigger, counts waiting cycles, flags the TIMEOUT-th one.
// Combinational expire output; no backpressure.
module det_timeout_cnt #(
   parameter int TIMEOUT = 63
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_clr,
   input  logic i_cnt,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign o_expired = i_cnt && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_cnt && !o_expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_row_bound_ctrl.sv
// Finds left/right pixel bounds of one image row by feeding BRAM words to an external detector.
// Per word: 3 cycles plus detector latency; starts are ignored while a scan is in flight.
module scan_row_bound_ctrl
   import scan_row_bound_ctrl_pkg::*;
#(
   parameter int WORDS_PER_ROW = 20,
   parameter int DET_TIMEOUT   = 63
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_row_base_addr,
   output logic [ADDR_W-1:0] o_bram_addr,
   input  logic [DATA_W-1:0] i_bram_rdata,
   output logic              o_det_trig,
   output logic [DATA_W-1:0] o_det_data,
   output logic              o_det_left_or_right,
   input  logic [IDX_W-1:0]  i_det_bound_index,
   input  logic              i_det_is_bound_detected,
   input  logic              i_det_done,
   output logic              o_busy,
   output logic [COL_W-1:0]  o_left_col,
   output logic [COL_W-1:0]  o_right_col,
   output logic              o_row_valid,
   output logic              o_err,
   output logic              o_done
);

   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_ROW - 1);

   logic [1:0]        rst_sync_q;
   logic              rst_n;

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] base_q,      base_d;
   logic [OFF_W-1:0]  off_q,       off_d;
   logic [OFF_W-1:0]  left_off_q,  left_off_d;
   logic              dir_q,       dir_d;
   logic [DATA_W-1:0] data_q,      data_d;
   logic [COL_W-1:0]  left_col_q,  left_col_d;
   logic [COL_W-1:0]  right_col_q, right_col_d;
   logic              valid_q,     valid_d;
   logic              err_q,       err_d;

   logic              tmo_expired;
   logic [COL_W-1:0]  cur_col;

   // Reset asserts asynchronously but releases only after two clock edges.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n = rst_sync_q[1];

   det_timeout_cnt #(
      .TIMEOUT (DET_TIMEOUT)
   ) u_det_timeout_cnt (
      .i_clk     (i_clk),
      .i_rstn    (rst_n),
      .i_clr     (state_q == DET),
      .i_cnt     (state_q == WAIT_DET),
      .o_expired (tmo_expired)
   );

   assign cur_col = word_bit_to_col(off_q, i_det_bound_index);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      off_d       = off_q;
      left_off_d  = left_off_q;
      dir_d       = dir_q;
      data_d      = data_q;
      left_col_d  = left_col_q;
      right_col_d = right_col_q;
      valid_d     = valid_q;
      err_d       = err_q;
      o_bram_addr = '0;
      o_det_trig  = 1'b0;
      o_done      = 1'b0;
      o_busy      = (state_q != IDLE) && (state_q != FINISH);

      case (state_q)
         IDLE: begin
            if (i_start) begin
               base_d      = i_row_base_addr;
               err_d       = 1'b0;
               valid_d     = 1'b0;
               left_col_d  = '0;
               right_col_d = '0;
               off_d       = '0;
               left_off_d  = '0;
               dir_d       = DIR_LEFT;
               state_d     = RD;
            end
         end
         RD: begin
            o_bram_addr = base_q + ADDR_W'(off_q);
            state_d     = WAIT_RD;
         end
         WAIT_RD: begin
            o_bram_addr = base_q + ADDR_W'(off_q);
            data_d      = i_bram_rdata;
            state_d     = DET;
         end
         DET: begin
            o_det_trig = 1'b1;
            state_d    = WAIT_DET;
         end
         WAIT_DET: begin
            if (i_det_done) begin
               if (dir_q == DIR_LEFT) begin
                  if (i_det_is_bound_detected) begin
                     left_col_d = cur_col;
                     left_off_d = off_q;
                     dir_d      = DIR_RIGHT;
                     off_d      = LAST_OFF;
                     state_d    = RD;
                  end else if (off_q == LAST_OFF) begin
                     valid_d     = 1'b0;
                     left_col_d  = '0;
                     right_col_d = '0;
                     state_d     = FINISH;
                  end else begin
                     off_d   = off_q + OFF_W'(1);
                     state_d = RD;
                  end
               end else begin
                  if (i_det_is_bound_detected) begin
                     right_col_d = cur_col;
                     valid_d     = 1'b1;
                     state_d     = FINISH;
                  end else if (off_q <= left_off_q) begin
                     // The left-bound word bounds the right pass from below.
                     right_col_d = left_col_q;
                     valid_d     = 1'b1;
                     state_d     = FINISH;
                  end else begin
                     off_d   = off_q - OFF_W'(1);
                     state_d = RD;
                  end
               end
            end else if (tmo_expired) begin
               err_d       = 1'b1;
               valid_d     = 1'b0;
               left_col_d  = '0;
               right_col_d = '0;
               state_d     = FINISH;
            end
         end
         FINISH: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         off_q       <= '0;
         left_off_q  <= '0;
         dir_q       <= DIR_LEFT;
         data_q      <= '0;
         left_col_q  <= '0;
         right_col_q <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         off_q       <= off_d;
         left_off_q  <= left_off_d;
         dir_q       <= dir_d;
         data_q      <= data_d;
         left_col_q  <= left_col_d;
         right_col_q <= right_col_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign o_det_data          = data_q;
   assign o_det_left_or_right = dir_q;
   assign o_left_col          = left_col_q;
   assign o_right_col         = right_col_q;
   assign o_row_valid         = valid_q;
   assign o_err               = err_q;

endmodule

// File: tb/tb_scan_row_bound_ctrl.sv
// Bench for scan_row_bound_ctrl: BRAM and detector models plus a row-search reference model.
module tb_scan_row_bound_ctrl;

   localparam int W = 20;

   logic        clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_start = 1'b0;
   logic [12:0] i_row_base_addr = '0;
   logic [12:0] o_bram_addr;
   logic [31:0] bram_rdata = '0;
   logic        o_det_trig;
   logic [31:0] o_det_data;
   logic        o_det_lr;
   logic [4:0]  det_index = '0;
   logic        det_detected = 1'b0;
   logic        det_done = 1'b0;
   logic        o_busy;
   logic [9:0]  o_left_col;
   logic [9:0]  o_right_col;
   logic        o_row_valid;
   logic        o_err;
   logic        o_done;

   always #5 clk = ~clk;

   scan_row_bound_ctrl #(.WORDS_PER_ROW(W), .DET_TIMEOUT(63)) dut (
      .i_clk                   (clk),
      .i_rstn                  (i_rstn),
      .i_start                 (i_start),
      .i_row_base_addr         (i_row_base_addr),
      .o_bram_addr             (o_bram_addr),
      .i_bram_rdata            (bram_rdata),
      .o_det_trig              (o_det_trig),
      .o_det_data              (o_det_data),
      .o_det_left_or_right     (o_det_lr),
      .i_det_bound_index       (det_index),
      .i_det_is_bound_detected (det_detected),
      .i_det_done              (det_done),
      .o_busy                  (o_busy),
      .o_left_col              (o_left_col),
      .o_right_col             (o_right_col),
      .o_row_valid             (o_row_valid),
      .o_err                   (o_err),
      .o_done                  (o_done)
   );

   logic [31:0] mem [0:8191];
   logic [31:0] row [0:W-1];
   always @(posedge clk) bram_rdata <= mem[o_bram_addr];

   int n_cmp = 0;
   int n_bad = 0;

   int  cyc = 0;
   int  det_lat = 2;
   bit  det_mute = 0;
   bit  det_suppress = 0;
   int  pend = 0;
   logic [31:0] pend_word;
   logic        pend_dir;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  trig_addr_q[$];
   logic trig_dir_q[$];
   logic [31:0] trig_data_q[$];
   int  trig_cyc_q[$];
   int  last_addr = 0;

   int   exp_addr[$];
   logic exp_dir[$];
   logic exp_valid;
   int   exp_left;
   int   exp_right;

   function automatic int lowbit(input logic [31:0] w);
      for (int b = 0; b < 32; b++) if (w[b]) return b;
      return 0;
   endfunction

   function automatic int highbit(input logic [31:0] w);
      for (int b = 31; b >= 0; b--) if (w[b]) return b;
      return 0;
   endfunction

   // Detector model and monitor, both acting away from the active edge.
   always @(negedge clk) begin
      cyc++;
      det_done = 1'b0;
      det_detected = 1'b0;
      det_index = '0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            det_done = 1'b1;
            if (pend_dir == 1'b0) begin
               det_detected = (pend_word != 0);
               det_index = 5'(lowbit(pend_word));
            end else begin
               det_detected = !det_suppress && (pend_word != 0);
               det_index = 5'(highbit(pend_word));
            end
         end
      end
      if (o_det_trig) begin
         trig_addr_q.push_back(last_addr);
         trig_dir_q.push_back(o_det_lr);
         trig_data_q.push_back(o_det_data);
         trig_cyc_q.push_back(cyc);
         if (!det_mute) begin
            pend = det_lat;
            pend_word = o_det_data;
            pend_dir = o_det_lr;
         end
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      last_addr = int'(o_bram_addr);
   end

   task automatic clear_mon();
      trig_addr_q.delete();
      trig_dir_q.delete();
      trig_data_q.delete();
      trig_cyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic load_row(input int base);
      for (int i = 0; i < W; i++) mem[(base + i) % 8192] = row[i];
   endtask

   // Reference: leftmost nonzero word gives the left bound, then the rightmost nonzero
   // word at or after it gives the right bound (or falls back to the left bound).
   task automatic model_scan(input int base, input bit suppress);
      int l;
      exp_addr.delete();
      exp_dir.delete();
      l = -1;
      for (int i = 0; i < W; i++) if (l < 0 && row[i] != 0) l = i;
      if (l < 0) begin
         for (int i = 0; i < W; i++) begin
            exp_addr.push_back((base + i) % 8192);
            exp_dir.push_back(1'b0);
         end
         exp_valid = 1'b0; exp_left = 0; exp_right = 0;
      end else begin
         for (int i = 0; i <= l; i++) begin
            exp_addr.push_back((base + i) % 8192);
            exp_dir.push_back(1'b0);
         end
         exp_left = l * 32 + lowbit(row[l]);
         exp_valid = 1'b1;
         for (int j = W - 1; j >= l; j--) begin
            exp_addr.push_back((base + j) % 8192);
            exp_dir.push_back(1'b1);
            if (!suppress && row[j] != 0) begin
               exp_right = j * 32 + highbit(row[j]);
               break;
            end
            if (j == l) begin
               exp_right = exp_left;
               break;
            end
         end
      end
   endtask

   function automatic int seq_errs();
      int e = 0;
      if (trig_addr_q.size() != exp_addr.size()) return 1000 + trig_addr_q.size();
      for (int i = 0; i < exp_addr.size(); i++)
         if (trig_addr_q[i] != exp_addr[i] || trig_dir_q[i] !== exp_dir[i] ||
             trig_data_q[i] !== mem[exp_addr[i]]) e++;
      return e;
   endfunction

   function automatic int gap_errs(input int lat);
      int e = 0;
      for (int i = 1; i < trig_cyc_q.size(); i++)
         if (trig_cyc_q[i] - trig_cyc_q[i-1] != 3 + lat) e++;
      return e;
   endfunction

   task automatic wait_done();
      int k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
   endtask

   task automatic run_scan(input int base);
      clear_mon();
      @(negedge clk); #1;
      i_row_base_addr = 13'(base);
      i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic clear_row();
      for (int i = 0; i < W; i++) row[i] = '0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      n_cmp++;
      if ({o_busy, o_done, o_det_trig, o_row_valid, o_err, o_det_lr} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {o_busy, o_done, o_det_trig, o_row_valid, o_err, o_det_lr});
      end
      i_rstn = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if ({o_left_col, o_right_col} !== 20'd0) begin
         n_bad++;
         $display("FAIL reset_cols: got %0d/%0d want 0/0", o_left_col, o_right_col);
      end
      n_cmp++;
      if ({o_bram_addr, o_det_data, o_busy} !== 46'd0) begin
         n_bad++;
         $display("FAIL reset_addr_data: addr %0h data %0h busy %0b want 0", o_bram_addr, o_det_data, o_busy);
      end
   endtask

   task automatic check_result(input string name);
      n_cmp++;
      if (done_cnt !== 1) begin
         n_bad++;
         $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
      end
      n_cmp++;
      if ({o_row_valid, 10'(o_left_col), 10'(o_right_col), o_err} !==
          {exp_valid, 10'(exp_left), 10'(exp_right), 1'b0}) begin
         n_bad++;
         $display("FAIL %s result: got v%0b l%0d r%0d e%0b want v%0b l%0d r%0d e0", name,
                  o_row_valid, o_left_col, o_right_col, o_err, exp_valid, exp_left, exp_right);
      end
      n_cmp++;
      if (seq_errs() !== 0) begin
         n_bad++;
         $display("FAIL %s read_seq: %0d bad entries (got %0d reads want %0d)", name,
                  seq_errs(), trig_addr_q.size(), exp_addr.size());
      end
   endtask

   task automatic test_basic();
      clear_row();
      row[3] = 32'h1 << 7;
      row[5] = 32'h1 << 20;
      det_lat = 2; det_suppress = 0; det_mute = 0;
      load_row(32'h100);
      model_scan(32'h100, 0);
      run_scan(32'h100);
      n_cmp++;
      if ({o_left_col, o_right_col, o_row_valid} !== {10'd103, 10'd180, 1'b1}) begin
         n_bad++;
         $display("FAIL basic_cols: got %0d/%0d v%0b want 103/180 v1", o_left_col, o_right_col, o_row_valid);
      end
      check_result("basic");
      n_cmp++;
      if (gap_errs(2) !== 0) begin
         n_bad++;
         $display("FAIL basic_word_cost: %0d gaps differ from 5 cycles", gap_errs(2));
      end
   endtask

   task automatic test_empty_row();
      clear_row();
      load_row(32'h40);
      model_scan(32'h40, 0);
      run_scan(32'h40);
      n_cmp++;
      if (trig_addr_q.size() !== 20) begin
         n_bad++;
         $display("FAIL empty_trigs: got %0d want 20", trig_addr_q.size());
      end
      check_result("empty");
   endtask

   task automatic test_single_word();
      int nright = 0;
      clear_row();
      row[19] = (32'h1 << 4) | (32'h1 << 9);
      load_row(32'h200);
      model_scan(32'h200, 0);
      run_scan(32'h200);
      foreach (trig_dir_q[i]) if (trig_dir_q[i]) nright++;
      n_cmp++;
      if ({o_left_col, o_right_col, 6'(nright)} !== {10'd612, 10'd617, 6'd1}) begin
         n_bad++;
         $display("FAIL single_word: got %0d/%0d right_trigs %0d want 612/617 1", o_left_col, o_right_col, nright);
      end
      check_result("single");
   endtask

   task automatic test_right_fallback();
      int min_addr = 8192;
      clear_row();
      row[4] = 32'h0000_0F00;
      row[10] = 32'h8000_0000;
      det_suppress = 1;
      load_row(32'h300);
      model_scan(32'h300, 1);
      run_scan(32'h300);
      det_suppress = 0;
      foreach (trig_addr_q[i]) if (trig_addr_q[i] < min_addr) min_addr = trig_addr_q[i];
      n_cmp++;
      if ({o_right_col, o_left_col} !== {10'd136, 10'd136} || min_addr != 32'h300) begin
         n_bad++;
         $display("FAIL fallback: got l%0d r%0d min_addr %0h want 136/136 300", o_left_col, o_right_col, min_addr);
      end
      check_result("fallback");
   endtask

   task automatic test_timeout();
      clear_row();
      row[0] = 32'h1;
      det_mute = 1;
      load_row(32'h500);
      run_scan(32'h500);
      det_mute = 0;
      n_cmp++;
      if (done_cnt !== 1 || trig_cyc_q.size() !== 1) begin
         n_bad++;
         $display("FAIL timeout_count: done %0d trigs %0d want 1 1", done_cnt, trig_cyc_q.size());
      end else begin
         n_cmp++;
         if (done_cyc - trig_cyc_q[0] !== 64) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d want 64", done_cyc - trig_cyc_q[0]);
         end
      end
      n_cmp++;
      if ({o_err, o_row_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_flags: got err%0b valid%0b want err1 valid0", o_err, o_row_valid);
      end
   endtask

   task automatic test_wrap();
      clear_row();
      row[2] = 32'h8000_0001;
      load_row(32'h1FFE);
      model_scan(32'h1FFE, 0);
      run_scan(32'h1FFE);
      n_cmp++;
      if (trig_addr_q.size() < 3 || trig_addr_q[0] != 32'h1FFE || trig_addr_q[1] != 32'h1FFF ||
          trig_addr_q[2] != 0) begin
         n_bad++;
         $display("FAIL wrap_addr: first reads not 1FFE,1FFF,0000 (got %0d reads)", trig_addr_q.size());
      end
      check_result("wrap");
   endtask

   task automatic test_start_ignored();
      int trigs_at_done;
      clear_row();
      row[3] = 32'h0001_0000;
      row[8] = 32'h0000_0010;
      load_row(32'h700);
      model_scan(32'h700, 0);
      clear_mon();
      @(negedge clk); #1;
      i_row_base_addr = 13'h700; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      i_row_base_addr = 13'h0AAA; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      wait_done();
      i_row_base_addr = 13'h0555; i_start = 1'b1;
      trigs_at_done = trig_addr_q.size();
      @(negedge clk); #1;
      i_start = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_cmp++;
      if (trig_addr_q.size() !== trigs_at_done || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL start_on_done: trigs %0d->%0d busy %0b want no new scan", trigs_at_done,
                  trig_addr_q.size(), o_busy);
      end
      check_result("start_busy");
   endtask

   task automatic test_reset_mid();
      int k = 0;
      bit bad_zero = 0;
      clear_row();
      row[3] = 32'h1 << 7;
      row[5] = 32'h1 << 20;
      load_row(32'h100);
      det_mute = 1;
      clear_mon();
      @(negedge clk); #1;
      i_row_base_addr = 13'h100; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      while (trig_cyc_q.size() == 0 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      repeat (3) @(negedge clk);
      #2 i_rstn = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         if ({o_busy, o_done, o_det_trig, o_row_valid, o_err, o_det_lr, o_bram_addr,
              o_det_data, o_left_col, o_right_col} !== '0) bad_zero = 1;
         @(negedge clk); #1;
      end
      n_cmp++;
      if (bad_zero !== 1'b0 || k >= 200) begin
         n_bad++;
         $display("FAIL reset_mid_zero: outputs nonzero during reset (wait %0d)", k);
      end
      i_rstn = 1'b1;
      det_mute = 0;
      repeat (6) @(negedge clk);
      #1;
      n_cmp++;
      if (done_cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_stale_done: got %0d done pulses want 0", done_cnt);
      end
      model_scan(32'h100, 0);
      run_scan(32'h100);
      check_result("after_reset");
   endtask

   task automatic test_random();
      int base;
      bit sup;
      string nm;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 3))
               0: row[i] = $urandom;
               1: row[i] = 32'h1 << $urandom_range(0, 31);
               default: row[i] = '0;
            endcase
         end
         if ($urandom_range(0, 4) == 0) clear_row();
         base = $urandom_range(0, 8191);
         sup = ($urandom_range(0, 3) == 0);
         det_lat = $urandom_range(1, 4);
         det_suppress = sup;
         load_row(base);
         model_scan(base, sup);
         run_scan(base);
         nm = $sformatf("rand%0d", it);
         check_result(nm);
         n_cmp++;
         if (gap_errs(det_lat) !== 0) begin
            n_bad++;
            $display("FAIL %s word_cost: %0d gaps differ from %0d", nm, gap_errs(det_lat), 3 + det_lat);
         end
      end
      det_suppress = 0;
      det_lat = 2;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_row();
      test_single_word();
      test_right_fallback();
      test_timeout();
      test_wrap();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
